elevador_scan: RTL and testbench

- Parametrised successor to the small elevator controller: N_FLOORS floors, configurable car capacity, tick rate and door dwell.
- Adds SCAN (direction-sticky) call service, an explicit DOOR state with dwell timer, and asynchronous reset.
- Sits between board I/O (switch/key conditioning) and display/LED decode; outputs are raw state, with no 7-segment encoding.

---
 rtl/elevador_pkg.sv | 42 ++++
 rtl/elev_tick_div.sv | 28 ++
 rtl/elevador_scan.sv | 198 +++++++++++++++++++
 tb/tb_elevador_scan.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/elevador_pkg.sv
// Shared types and helpers for the elevador_scan elevator controller.
//   state_t : controller states (IDLE, MOVE_UP, MOVE_DOWN, DOOR, EMERG)
//   dir_t   : sticky travel direction remembered between stops
//   calls_above / calls_below : is there any pending call strictly beyond
//   a given floor in that direction (masked OR-reduction over 16 floors)
package elevador_pkg;

  localparam int MAX_FLOORS = 16;

  typedef enum logic [2:0] {
    IDLE,
    MOVE_UP,
    MOVE_DOWN,
    DOOR,
    EMERG
  } state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Callers zero-extend their call vector to MAX_FLOORS bits.
  function automatic logic calls_above(input logic [MAX_FLOORS-1:0] req_vec,
                                       input logic [3:0]            pos);
    logic any;
    any = 1'b0;
    for (int i = 0; i < MAX_FLOORS; i++)
      if (i > int'(pos)) any = any | req_vec[i];
    return any;
  endfunction

  function automatic logic calls_below(input logic [MAX_FLOORS-1:0] req_vec,
                                       input logic [3:0]            pos);
    logic any;
    any = 1'b0;
    for (int i = 0; i < MAX_FLOORS; i++)
      if (i < int'(pos)) any = any | req_vec[i];
    return any;
  endfunction

endpackage

// File: rtl/elev_tick_div.sv
// Movement tick generator: a free-running counter 0..TICK_DIV-1 that wraps.
//   CLOCK_50 : system clock
//   rst_n    : asynchronous active-low reset (counter to 0)
//   tick     : high for exactly one cycle while the count equals TICK_DIV-1
module elev_tick_div #(
  parameter int TICK_DIV = 50000000
) (
  input  logic CLOCK_50,
  input  logic rst_n,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // NOTE: clocked state is assigned with <= so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                 cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/elevador_scan.sv
// SCAN elevator controller with door dwell, capacity limit and emergency
// descent. Outputs are raw state for downstream LED / display decode.
//   CLOCK_50   : system clock           rst_n      : async active-low reset
//   call_req   : level call per floor   add_person : rising edge = +1 person
//   rem_person : rising edge = -1       emerg_req  : rising edge = emergency
//   floor      : current floor index    dir_up/dir_down : travel direction
//   calls      : pending calls          people/full: occupancy
//   emergency  : in emergency descent   door_open  : door dwell in progress
module elevador_scan
  import elevador_pkg::*;
#(
  parameter  int N_FLOORS   = 5,
  parameter  int CAPACITY   = 3,
  parameter  int TICK_DIV   = 50000000,
  parameter  int DOOR_TICKS = 2,
  localparam int FW         = $clog2(N_FLOORS),
  localparam int PW         = $clog2(CAPACITY + 1)
) (
  input  logic                CLOCK_50,
  input  logic                rst_n,
  input  logic [N_FLOORS-1:0] call_req,
  input  logic                add_person,
  input  logic                rem_person,
  input  logic                emerg_req,
  output logic [FW-1:0]       floor,
  output logic                dir_up,
  output logic                dir_down,
  output logic [N_FLOORS-1:0] calls,
  output logic [PW-1:0]       people,
  output logic                full,
  output logic                emergency,
  output logic                door_open
);

  localparam int            DW        = $clog2(DOOR_TICKS + 1);
  localparam logic [DW-1:0] DOOR_LOAD = DW'(DOOR_TICKS);
  localparam logic [PW-1:0] CAP       = PW'(CAPACITY);
  localparam logic [FW-1:0] TOP_FLOOR = FW'(N_FLOORS - 1);

  state_t        state;
  dir_t          last_dir;
  logic [DW-1:0] dwell;
  logic          add_prev, rem_prev, emerg_prev;
  logic          tick;

  elev_tick_div #(.TICK_DIV(TICK_DIV)) u_tick (
    .CLOCK_50 (CLOCK_50),
    .rst_n    (rst_n),
    .tick     (tick)
  );

  logic add_edge, rem_edge, emerg_edge;
  assign add_edge   = add_person & ~add_prev;
  assign rem_edge   = rem_person & ~rem_prev;
  assign emerg_edge = emerg_req  & ~emerg_prev;

  // One-hot masks for the current floor and its neighbours.
  logic [N_FLOORS-1:0] cur_bit, up_bit, down_bit, clr;
  assign cur_bit  = N_FLOORS'(1) << floor;
  assign up_bit   = cur_bit << 1;
  assign down_bit = cur_bit >> 1;

  logic here_call, up_call, down_call, ahead_up, ahead_down, idle_go;
  assign here_call  = |(calls & cur_bit);
  assign up_call    = |(calls & up_bit);
  assign down_call  = |(calls & down_bit);
  assign ahead_up   = calls_above(MAX_FLOORS'(calls), 4'(floor));
  assign ahead_down = calls_below(MAX_FLOORS'(calls), 4'(floor));
  assign idle_go    = tick & (|calls) & ~full;

  // The call bit for whichever floor the car is stopping at this cycle.
  // NOTE: clr is given a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    clr = '0;
    case (state)
      IDLE:      if (idle_go && here_call) clr = cur_bit;
      MOVE_UP:   if (tick && up_call)      clr = up_bit;
      MOVE_DOWN: if (tick && down_call)    clr = down_bit;
      DOOR:      clr = cur_bit;  // a call for the open floor is absorbed
      default:   clr = '0;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_dir   <= DIR_UP;
      floor      <= '0;
      calls      <= '0;
      people     <= '0;
      emergency  <= 1'b0;
      dwell      <= '0;
      add_prev   <= 1'b0;
      rem_prev   <= 1'b0;
      emerg_prev <= 1'b0;
    end else begin
      add_prev   <= add_person;
      rem_prev   <= rem_person;
      emerg_prev <= emerg_req;

      if (state != EMERG && emerg_edge) begin
        // Emergency entry overrides every other event in this cycle.
        state     <= EMERG;
        calls     <= '0;
        emergency <= 1'b1;
        dwell     <= '0;
      end else if (state == EMERG) begin
        calls <= '0;
        if (tick) begin
          if (floor != '0) begin
            floor <= floor - 1'b1;
          end else begin
            state     <= DOOR;
            emergency <= 1'b0;
            dwell     <= DOOR_LOAD;
          end
        end
      end else begin
        calls <= (calls | call_req) & ~clr;

        if (add_edge && !rem_edge && people != CAP)
          people <= people + 1'b1;
        else if (rem_edge && !add_edge && people != '0)
          people <= people - 1'b1;

        case (state)
          IDLE: begin
            if (idle_go) begin
              if (here_call) begin
                state <= DOOR;
                dwell <= DOOR_LOAD;
              end else if (last_dir == DIR_UP) begin
                if (ahead_up) begin
                  state <= MOVE_UP;
                end else begin
                  state    <= MOVE_DOWN;
                  last_dir <= DIR_DOWN;
                end
              end else begin
                if (ahead_down) begin
                  state <= MOVE_DOWN;
                end else begin
                  state    <= MOVE_UP;
                  last_dir <= DIR_UP;
                end
              end
            end
          end
          MOVE_UP: begin
            if (tick) begin
              floor <= floor + 1'b1;
              if (up_call) begin
                state <= DOOR;
                dwell <= DOOR_LOAD;
              end
            end
          end
          MOVE_DOWN: begin
            if (tick) begin
              floor <= floor - 1'b1;
              if (down_call) begin
                state <= DOOR;
                dwell <= DOOR_LOAD;
              end
            end
          end
          DOOR: begin
            if (tick) begin
              if (dwell > DW'(1)) begin
                dwell <= dwell - 1'b1;
              end else begin
                state <= IDLE;
                dwell <= '0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign dir_up    = (state == MOVE_UP);
  assign dir_down  = (state == MOVE_DOWN) || (state == EMERG);
  assign door_open = (state == DOOR);
  assign full      = (people == CAP);

  // A move state always has its target call still pending ahead, so the
  // floor index can never step outside 0..N_FLOORS-1.
  a_floor_range: assert property (@(posedge CLOCK_50) disable iff (!rst_n)
    floor <= TOP_FLOOR);
  a_up_target: assert property (@(posedge CLOCK_50) disable iff (!rst_n)
    (state == MOVE_UP) |-> (floor < TOP_FLOOR && ahead_up));
  a_down_target: assert property (@(posedge CLOCK_50) disable iff (!rst_n)
    (state == MOVE_DOWN) |-> (floor != '0 && ahead_down));

endmodule

// File: tb/tb_elevador_scan.sv
// Directed bench for elevador_scan with N_FLOORS=5, CAPACITY=3, TICK_DIV=4,
// DOOR_TICKS=2. The bench tracks tick edges itself: after reset release the
// 4th rising edge and every 4th one after it carries a movement tick.
module tb_elevador_scan;

  localparam int N = 5;

  logic         CLOCK_50;
  logic         rst_n;
  logic [N-1:0] call_req;
  logic         add_person, rem_person, emerg_req;
  logic [2:0]   floor;
  logic         dir_up, dir_down, full, emergency, door_open;
  logic [N-1:0] calls;
  logic [1:0]   people;

  int checks = 0;
  int errors = 0;
  int edge_n;

  elevador_scan #(
    .N_FLOORS   (N),
    .CAPACITY   (3),
    .TICK_DIV   (4),
    .DOOR_TICKS (2)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .rst_n      (rst_n),
    .call_req   (call_req),
    .add_person (add_person),
    .rem_person (rem_person),
    .emerg_req  (emerg_req),
    .floor      (floor),
    .dir_up     (dir_up),
    .dir_down   (dir_down),
    .calls      (calls),
    .people     (people),
    .full       (full),
    .emergency  (emergency),
    .door_open  (door_open)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Rising edges since reset release; tick edges are the multiples of 4.
  always @(posedge CLOCK_50 or negedge rst_n)
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge CLOCK_50);
  endtask

  // Advance to the falling edge just after the next tick edge.
  task automatic tick_step();
    do @(negedge CLOCK_50); while (edge_n % 4 != 0);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick_step();
  endtask

  task automatic pulse_call(input logic [N-1:0] v);
    call_req = v;
    step();
    call_req = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; call_req = '0;
    add_person = 1'b0; rem_person = 1'b0; emerg_req = 1'b0;

    // Reset held with random inputs.
    for (int i = 0; i < 6; i++) begin
      step();
      call_req   = 5'($urandom);
      add_person = 1'($urandom);
      rem_person = 1'($urandom);
      emerg_req  = 1'($urandom);
    end
    step();
    check("rst_floor",     32'(floor),     0);
    check("rst_calls",     32'(calls),     0);
    check("rst_people",    32'(people),    0);
    check("rst_full",      32'(full),      0);
    check("rst_dir_up",    32'(dir_up),    0);
    check("rst_dir_down",  32'(dir_down),  0);
    check("rst_emergency", 32'(emergency), 0);
    check("rst_door",      32'(door_open), 0);
    call_req = '0; add_person = 1'b0; rem_person = 1'b0; emerg_req = 1'b0;
    step();
    rst_n = 1'b1;

    // No stimulus for 20 ticks: stays idle at ground.
    ticks(20);
    check("idle_floor", 32'(floor),     0);
    check("idle_up",    32'(dir_up),    0);
    check("idle_door",  32'(door_open), 0);

    // Single call to floor 3.
    pulse_call(5'b01000);
    check("sc_latch", 32'(calls), 'b01000);
    tick_step();
    check("sc_dir_up", 32'(dir_up), 1);
    check("sc_f0",     32'(floor),  0);
    tick_step(); check("sc_f1", 32'(floor), 1);
    tick_step(); check("sc_f2", 32'(floor), 2);
    tick_step();
    check("sc_f3",    32'(floor),     3);
    check("sc_clear", 32'(calls),     0);
    check("sc_door",  32'(door_open), 1);
    tick_step(); check("sc_door2", 32'(door_open), 1);
    tick_step();
    check("sc_closed", 32'(door_open), 0);
    check("sc_idle",   32'(dir_up),    0);

    // Call below with last direction up: reverse.
    pulse_call(5'b00001);
    tick_step();
    check("rev_dir_down", 32'(dir_down), 1);
    check("rev_f3",       32'(floor),    3);
    ticks(3);
    check("rev_f0",   32'(floor),     0);
    check("rev_door", 32'(door_open), 1);
    ticks(2);
    check("rev_closed", 32'(door_open), 0);

    // SCAN: heading to 4, a call for 1 raised at floor 2 waits.
    pulse_call(5'b10000);
    tick_step(); check("scan_dir_up", 32'(dir_up), 1);
    ticks(2);
    check("scan_f2", 32'(floor), 2);
    pulse_call(5'b00010);
    check("scan_calls", 32'(calls), 'b10010);
    tick_step();
    check("scan_f3",    32'(floor),  3);
    check("scan_up_f3", 32'(dir_up), 1);
    tick_step();
    check("scan_f4",      32'(floor),     4);
    check("scan_door4",   32'(door_open), 1);
    check("scan_left1",   32'(calls),     'b00010);
    ticks(2);
    check("scan_closed4", 32'(door_open), 0);
    tick_step();
    check("scan_down_f4", 32'(dir_down), 1);
    tick_step();
    check("scan_down_f3", 32'(dir_down), 1);
    check("scan_f3b",     32'(floor),    3);
    tick_step();
    check("scan_down_f2", 32'(dir_down), 1);
    check("scan_f2b",     32'(floor),    2);
    tick_step();
    check("scan_f1",    32'(floor),     1);
    check("scan_door1", 32'(door_open), 1);
    check("scan_empty", 32'(calls),     0);
    ticks(2);

    // Capacity: four add edges saturate at 3.
    repeat (4) begin
      add_person = 1'b1; step();
      add_person = 1'b0; step();
    end
    check("cap_people", 32'(people), 3);
    check("cap_full",   32'(full),   1);
    tick_step();
    pulse_call(5'b10000);
    ticks(5);
    check("cap_hold_floor", 32'(floor),  1);
    check("cap_hold_up",    32'(dir_up), 0);
    check("cap_hold_calls", 32'(calls),  'b10000);
    rem_person = 1'b1; step(); rem_person = 1'b0;
    check("cap_rem_people", 32'(people), 2);
    check("cap_rem_full",   32'(full),   0);
    tick_step();
    check("cap_depart", 32'(dir_up), 1);
    ticks(3);
    check("cap_f4",   32'(floor),     4);
    check("cap_door", 32'(door_open), 1);
    add_person = 1'b1; rem_person = 1'b1; step();
    add_person = 1'b0; rem_person = 1'b0;
    check("cap_both", 32'(people), 2);
    ticks(2);

    // Emergency from the door at floor 3 with calls 10011.
    pulse_call(5'b01000);
    tick_step(); check("em_setup_down", 32'(dir_down), 1);
    tick_step();
    check("em_setup_f3",   32'(floor),     3);
    check("em_setup_door", 32'(door_open), 1);
    pulse_call(5'b10011);
    check("em_calls", 32'(calls), 'b10011);
    emerg_req = 1'b1; step();
    check("em_cleared",  32'(calls),     0);
    check("em_flag",     32'(emergency), 1);
    check("em_door_off", 32'(door_open), 0);
    check("em_f3",       32'(floor),     3);
    emerg_req = 1'b0; add_person = 1'b1; call_req = 5'b00100;
    step();
    call_req = '0; add_person = 1'b0;
    check("em_ign_people", 32'(people), 2);
    check("em_ign_calls",  32'(calls),  0);
    tick_step();
    check("em_f2",  32'(floor),    2);
    check("em_dir", 32'(dir_down), 1);
    tick_step(); check("em_f1", 32'(floor), 1);
    tick_step();
    check("em_f0",      32'(floor),     0);
    check("em_still",   32'(emergency), 1);
    tick_step();
    check("em_door",    32'(door_open), 1);
    check("em_done",    32'(emergency), 0);
    check("em_floor0",  32'(floor),     0);
    ticks(2);

    // Reset asserted mid-move takes effect before the next clock edge.
    pulse_call(5'b10000);
    tick_step(); check("rm_dir_up", 32'(dir_up), 1);
    ticks(2);
    check("rm_f2", 32'(floor), 2);
    #2 rst_n = 1'b0;
    #1;
    check("rm_floor",  32'(floor),  0);
    check("rm_dir_up", 32'(dir_up), 0);
    check("rm_calls",  32'(calls),  0);
    check("rm_people", 32'(people), 0);
    step();
    rst_n = 1'b1;
    ticks(2);
    check("rm_idle", 32'(dir_up), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
